// File: rtl/axi_lite_manager.sv
// AXI4-Lite manager: turns one valid/ready command into a single AXI4-Lite read or write
// and returns the data and response on a valid/ready response port. One transaction at a time.
module axi_lite_manager #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            dbg_state,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic [2:0]            m_axi_lite_awprot,
  output logic                  m_axi_lite_awvalid,
  input  logic                  m_axi_lite_awready,
  output logic [31:0]           m_axi_lite_wdata,
  output logic [3:0]            m_axi_lite_wstrb,
  output logic                  m_axi_lite_wvalid,
  input  logic                  m_axi_lite_wready,
  input  logic [1:0]            m_axi_lite_bresp,
  input  logic                  m_axi_lite_bvalid,
  output logic                  m_axi_lite_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic [2:0]            m_axi_lite_arprot,
  output logic                  m_axi_lite_arvalid,
  input  logic                  m_axi_lite_arready,
  input  logic [31:0]           m_axi_lite_rdata,
  input  logic [1:0]            m_axi_lite_rresp,
  input  logic                  m_axi_lite_rvalid,
  output logic                  m_axi_lite_rready
);

  // Handshake rule on every port: a transfer happens on a rising edge where valid and ready
  // are both high; valids here are registered, never derived from a ready, and once raised
  // stay high until that transfer.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state;

  assign busy              = (state != S_IDLE);
  assign dbg_state         = state;
  assign m_axi_lite_awprot = 3'b000;
  assign m_axi_lite_arprot = 3'b000;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= S_IDLE;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= '0;
      err                <= 1'b0;
      m_axi_lite_awaddr  <= '0;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wdata   <= '0;
      m_axi_lite_wstrb   <= '0;
      m_axi_lite_wvalid  <= 1'b0;
      m_axi_lite_bready  <= 1'b0;
      m_axi_lite_araddr  <= '0;
      m_axi_lite_arvalid <= 1'b0;
      m_axi_lite_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            err       <= 1'b0;
            if (cmd_write) begin
              m_axi_lite_awaddr  <= cmd_addr;
              m_axi_lite_wdata   <= cmd_wdata;
              m_axi_lite_wstrb   <= cmd_wstrb;
              m_axi_lite_awvalid <= 1'b1;
              m_axi_lite_wvalid  <= 1'b1;
              m_axi_lite_bready  <= 1'b1;
              state              <= S_WADDR;
            end else begin
              m_axi_lite_araddr  <= cmd_addr;
              m_axi_lite_arvalid <= 1'b1;
              m_axi_lite_rready  <= 1'b1;
              state              <= S_RADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        // AW and W retire independently; leave once neither is still outstanding.
        S_WADDR: begin
          if (m_axi_lite_awready) m_axi_lite_awvalid <= 1'b0;
          if (m_axi_lite_wready)  m_axi_lite_wvalid  <= 1'b0;
          if ((!m_axi_lite_awvalid || m_axi_lite_awready) &&
              (!m_axi_lite_wvalid  || m_axi_lite_wready))
            state <= S_WRESP;
        end

        S_WRESP: begin
          if (m_axi_lite_bvalid) begin
            rsp_rdata         <= '0;
            rsp_resp          <= m_axi_lite_bresp;
            if (m_axi_lite_bresp != 2'b00) err <= 1'b1;
            m_axi_lite_bready <= 1'b0;
            rsp_valid         <= 1'b1;
            state             <= S_DONE;
          end
        end

        S_RADDR: begin
          if (m_axi_lite_arready) begin
            m_axi_lite_arvalid <= 1'b0;
            state              <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (m_axi_lite_rvalid) begin
            rsp_rdata         <= m_axi_lite_rdata;
            rsp_resp          <= m_axi_lite_rresp;
            if (m_axi_lite_rresp != 2'b00) err <= 1'b1;
            m_axi_lite_rready <= 1'b0;
            rsp_valid         <= 1'b1;
            state             <= S_DONE;
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          cmd_ready          <= 1'b0;
          rsp_valid          <= 1'b0;
          m_axi_lite_awvalid <= 1'b0;
          m_axi_lite_wvalid  <= 1'b0;
          m_axi_lite_bready  <= 1'b0;
          m_axi_lite_arvalid <= 1'b0;
          m_axi_lite_rready  <= 1'b0;
          state              <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_manager.sv
// Directed bench for axi_lite_manager with a negedge-driven AXI4-Lite subordinate model
// (4 registers at 0x0..0xC, SLVERR above) whose ready/response delays are set per test.
module tb_axi_lite_manager;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic        err;
  logic [2:0]  dbg_state;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // subordinate model knobs (written by the tests) and state (written by the model only)
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [31:0] mem [4];
  logic        mem_init = 1'b0;
  logic        aw_got, w_got, r_pend, b_hs_next, r_hs_next;
  logic [31:0] cap_addr, cap_data, cap_raddr;
  logic [3:0]  cap_strb;
  int aw_cnt, w_cnt, ar_cnt, r_wait;
  int aw_hs_cyc = 0, w_hs_cyc = 0, b_count = 0, r_count = 0;
  int aw_vcnt = 0, w_vcnt = 0, ar_vcnt = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axi_lite_manager #(.ADDR_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy), .err(err), .dbg_state(dbg_state),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot),
    .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
    .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
    .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
    .m_axi_lite_araddr(araddr), .m_axi_lite_arprot(arprot),
    .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
    .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
  );

  // Subordinate: on each falling edge, first retire handshakes from the previous rising edge,
  // then decide what to present for the next one.
  always @(negedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      if (!mem_init) begin
        mem[0] = '0; mem[1] = 32'hDEAD_BEEF; mem[2] = '0; mem[3] = '0;
        mem_init = 1'b1;
      end
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0;
      aw_got = 0; w_got = 0; r_pend = 0; b_hs_next = 0; r_hs_next = 0;
      cap_addr = 0; cap_data = 0; cap_raddr = 0; cap_strb = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = 0;
    end else begin
      if (awready) begin awready = 0; aw_got = 1; aw_hs_cyc = cyc; end
      if (wready)  begin wready = 0;  w_got = 1;  w_hs_cyc = cyc;  end
      if (arready) begin arready = 0; r_pend = 1; r_wait = r_delay; end
      if (b_hs_next) begin bvalid = 0; b_count++; end
      if (r_hs_next) begin rvalid = 0; r_count++; end
      if (aw_got && w_got && !bvalid) begin
        if (cap_addr < 32'h10) begin
          for (int i = 0; i < 4; i++)
            if (cap_strb[i]) mem[cap_addr[3:2]][8*i +: 8] = cap_data[8*i +: 8];
          bresp = 2'b00;
        end else begin
          bresp = 2'b10;
        end
        bvalid = 1; aw_got = 0; w_got = 0;
      end
      if (awvalid && !awready && !aw_got) begin
        if (aw_cnt >= aw_delay) begin awready = 1; aw_cnt = 0; cap_addr = awaddr; end
        else aw_cnt++;
      end
      if (wvalid && !wready && !w_got) begin
        if (w_cnt >= w_delay) begin wready = 1; w_cnt = 0; cap_data = wdata; cap_strb = wstrb; end
        else w_cnt++;
      end
      if (arvalid && !arready && !r_pend && !rvalid) begin
        if (ar_cnt >= ar_delay) begin arready = 1; ar_cnt = 0; cap_raddr = araddr; end
        else ar_cnt++;
      end
      if (r_pend && !rvalid) begin
        if (r_wait == 0) begin
          rvalid = 1; r_pend = 0;
          if (cap_raddr < 32'h10) begin rdata = mem[cap_raddr[3:2]]; rresp = 2'b00; end
          else begin rdata = 0; rresp = 2'b10; end
        end else r_wait--;
      end
      if (awvalid) aw_vcnt++;
      if (wvalid)  w_vcnt++;
      if (arvalid) ar_vcnt++;
      b_hs_next = bvalid && bready;
      r_hs_next = rvalid && rready;
    end
  end

  // Presents a command at a falling edge and returns #1 after the accepting rising edge.
  task automatic send_cmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept_timeout cmd_ready=%b expected 1", cmd_ready);
    end
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts falling edges from acceptance until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge aclk); lat++; end while (!rsp_valid && lat < 200);
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout rsp_valid=%b expected 1", rsp_valid);
    end
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({cmd_ready, rsp_valid, busy, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b expected 0000", {cmd_ready, rsp_valid, busy, err});
    end
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_axi got=%b expected 00000", {awvalid, wvalid, arvalid, bready, rready});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || awaddr !== 32'h0 || wdata !== 32'h0 ||
        araddr !== 32'h0 || awprot !== 3'b000 || arprot !== 3'b000) begin
      failures++;
      $display("FAIL reset_data rdata=%h resp=%b awaddr=%h wdata=%h expected zeros",
               rsp_rdata, rsp_resp, awaddr, wdata);
    end
    aresetn = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready got=%b expected 0", cmd_ready);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL first_cycle_ready got=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    int lat;
    aw_delay = 0; w_delay = 0;
    send_cmd(1'b1, 32'h0, 32'h0000_00FF, 4'hF);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b expected 1", busy); end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL wr_latency got=%0d expected 3", lat); end
    checks++;
    if (aw_hs_cyc != w_hs_cyc) begin
      failures++;
      $display("FAIL wr_same_cycle aw_cyc=%0d w_cyc=%0d expected equal", aw_hs_cyc, w_hs_cyc);
    end
    checks++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp resp=%b rdata=%h err=%b expected 00/0/0", rsp_resp, rsp_rdata, err);
    end
    checks++;
    if (mem[0] !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL wr_mem got=%h expected 000000ff", mem[0]);
    end
    consume_rsp();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_ready cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_skew();
    int lat, b0, awv0, wv0;
    // AW late, W immediate
    aw_delay = 3; w_delay = 0;
    b0 = b_count; awv0 = aw_vcnt; wv0 = w_vcnt;
    send_cmd(1'b1, 32'h8, 32'h1234_5678, 4'h3);
    wait_rsp(lat);
    checks++;
    if (lat != 6) begin failures++; $display("FAIL skew_aw_latency got=%0d expected 6", lat); end
    checks++;
    if (!(w_hs_cyc < aw_hs_cyc) || (aw_vcnt - awv0) != 4 || (w_vcnt - wv0) != 1) begin
      failures++;
      $display("FAIL skew_aw_valids aw_hs=%0d w_hs=%0d awv=%0d wv=%0d expected w first, 4, 1",
               aw_hs_cyc, w_hs_cyc, aw_vcnt - awv0, w_vcnt - wv0);
    end
    checks++;
    if (rsp_resp !== 2'b00 || mem[2] !== 32'h0000_5678) begin
      failures++;
      $display("FAIL skew_aw_data resp=%b mem=%h expected 00/00005678", rsp_resp, mem[2]);
    end
    consume_rsp();
    checks++;
    if (b_count - b0 != 1) begin
      failures++;
      $display("FAIL skew_aw_bcount got=%0d expected 1", b_count - b0);
    end
    // W late, AW immediate
    aw_delay = 0; w_delay = 3;
    b0 = b_count; awv0 = aw_vcnt; wv0 = w_vcnt;
    send_cmd(1'b1, 32'hC, 32'hA5A5_A5A5, 4'hC);
    wait_rsp(lat);
    checks++;
    if (!(aw_hs_cyc < w_hs_cyc) || (aw_vcnt - awv0) != 1 || (w_vcnt - wv0) != 4) begin
      failures++;
      $display("FAIL skew_w_valids aw_hs=%0d w_hs=%0d awv=%0d wv=%0d expected aw first, 1, 4",
               aw_hs_cyc, w_hs_cyc, aw_vcnt - awv0, w_vcnt - wv0);
    end
    checks++;
    if (rsp_resp !== 2'b00 || mem[3] !== 32'hA5A5_0000) begin
      failures++;
      $display("FAIL skew_w_data resp=%b mem=%h expected 00/a5a50000", rsp_resp, mem[3]);
    end
    consume_rsp();
    checks++;
    if (b_count - b0 != 1) begin
      failures++;
      $display("FAIL skew_w_bcount got=%0d expected 1", b_count - b0);
    end
    w_delay = 0;
  endtask

  task automatic test_read_wait();
    int lat, arv0;
    ar_delay = 1; r_delay = 2;
    arv0 = ar_vcnt;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (lat != 6) begin failures++; $display("FAIL rd_latency got=%0d expected 6", lat); end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00 || err !== 1'b0) begin
      failures++;
      $display("FAIL rd_data rdata=%h resp=%b err=%b expected deadbeef/00/0",
               rsp_rdata, rsp_resp, err);
    end
    checks++;
    if (ar_vcnt - arv0 != 2) begin
      failures++;
      $display("FAIL rd_arvalid_cycles got=%0d expected 2", ar_vcnt - arv0);
    end
    consume_rsp();
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_slverr();
    int lat;
    send_cmd(1'b1, 32'h10, 32'h0000_0001, 4'hF);
    wait_rsp(lat);
    checks++;
    if (rsp_resp !== 2'b10 || err !== 1'b1) begin
      failures++;
      $display("FAIL slverr_rsp resp=%b err=%b expected 10/1", rsp_resp, err);
    end
    consume_rsp();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b expected 1", err); end
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b expected 0", err); end
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_rdata !== 32'h0000_00FF || rsp_resp !== 2'b00) begin
      failures++;
      $display("FAIL rd_after_err lat=%0d rdata=%h resp=%b expected 3/000000ff/00",
               lat, rsp_rdata, rsp_resp);
    end
    consume_rsp();
  endtask

  task automatic test_rsp_backpressure();
    int lat;
    send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    wait_rsp(lat);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h5555_5555;
    cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_5678 || rsp_resp !== 2'b00 ||
          cmd_ready !== 1'b0 || {awvalid, wvalid, arvalid, bready, rready} !== 5'b00000) begin
        failures++;
        $display("FAIL hold_cycle%0d rsp_valid=%b rdata=%h cmd_ready=%b axi=%b expected 1/00005678/0/00000",
                 i, rsp_valid, rsp_rdata, cmd_ready, {awvalid, wvalid, arvalid, bready, rready});
      end
    end
    cmd_valid = 1'b0;
    consume_rsp();
    @(negedge aclk);
    checks++;
    if (rsp_valid !== 1'b0 || mem[0] !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL hold_release rsp_valid=%b mem0=%h expected 0/000000ff", rsp_valid, mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    aw_delay = 1000;
    send_cmd(1'b1, 32'h0, 32'h0000_0011, 4'hF);
    @(negedge aclk);
    checks++;
    if (awvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_awvalid_pre got=%b expected 1", awvalid);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, busy, rsp_valid, cmd_ready} !== 6'b000000) begin
      failures++;
      $display("FAIL mid_reset got=%b expected 000000",
               {awvalid, wvalid, bready, busy, rsp_valid, cmd_ready});
    end
    @(negedge aclk);
    aresetn = 1'b1;
    aw_delay = 0;
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_rdata !== 32'h0000_00FF || rsp_resp !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_read lat=%0d rdata=%h resp=%b expected 3/000000ff/00",
               lat, rsp_rdata, rsp_resp);
    end
    consume_rsp();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_skew();
    test_read_wait();
    test_slverr();
    test_rsp_backpressure();
    test_reset_mid();
    repeat (2) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_manager.md
# axi_lite_manager

AXI4-Lite manager (initiator) that turns single-word commands from a simple valid/ready request port into one AXI4-Lite read or write transaction and returns the result on a valid/ready response port. It sits between a sequencer or PS-side command FIFO and AXI4-Lite register subordinates such as the ADC configuration block. It drives the config, status and AXIS-forwarding registers without CPU involvement.

## Interface
- ADDR_WIDTH, 32, width of AXI address and cmd_addr.
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  reset, asynchronous, active-low; clock aclk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data (ignored for reads).
- cmd_wstrb  in  4  byte strobes (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 after writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky: set on any non-OKAY response, cleared on next command acceptance.
- m_axi_lite_* : full AXI4-Lite manager channel set (awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready); awprot = arprot = 3'b000 constant.

## Operation
- States: IDLE, WADDR (AW and/or W outstanding), WRESP, RADDR, RDATA, DONE.
- IDLE: cmd_ready = 1. On cmd_valid: latch addr/wdata/wstrb/write, clear err, go WADDR (write) or RADDR (read).
- WADDR: awvalid and wvalid both asserted from the cycle after acceptance. Each deasserts the cycle after its own handshake, independently; either order or simultaneous is legal. When both handshakes have completed, go WRESP. bready = 1 throughout WADDR and WRESP.
- WRESP: on bvalid, capture bresp into rsp_resp, rsp_rdata = 0, go DONE.
- RADDR: arvalid asserted until arready, then go RDATA; rready = 1 in RADDR and RDATA.
- RDATA: on rvalid, capture rdata/rresp, go DONE.
- DONE: rsp_valid = 1, rsp_* held stable until rsp_ready, then IDLE. cmd_ready stays 0 in DONE, so there is no overlap of transactions.
- err set in the cycle the response is captured if resp != 2'b00.
- Valid signals never depend combinationally on ready inputs; once asserted, a valid is held until its handshake (AXI rule).
- Illegal/unused state encodings return to IDLE.

## Timing
- Reset values: cmd_ready 0 (1 from the first cycle after reset release), rsp_valid 0, rsp_rdata 0, rsp_resp 0, busy 0, err 0, all m_axi valids 0, bready/rready 0, addresses/data 0.
- Write latency with zero-wait subordinate: accept at edge N; awvalid/wvalid high N+1; B captured at the first bvalid edge; rsp_valid one cycle after capture. Minimum cmd-accept to rsp_valid is 3 cycles.
- Read latency is the same: arvalid at N+1, R capture, then rsp_valid the following cycle.
- Back-to-back: next cmd_ready is 1 in the cycle after the rsp handshake.
- Reset mid-operation: all valids and readies drop asynchronously, state goes to IDLE, and any pending response is discarded.
- Unbounded wait on subordinate; no timeout.

## Test plan
- Write 0x0000_00FF, strb 0xF, to 0x0 against a zero-wait subordinate model -> AW/W handshake in the same cycle, rsp_valid 3 cycles after accept, rsp_resp 00, err 0, model register = 0xFF.
- Write with awready delayed 3 cycles and wready immediate (then the reverse) -> wvalid drops after its own handshake, awvalid held, exactly one B accepted, rsp_resp 00.
- Read 0x4 with model returning 0xDEAD_BEEF after 2 wait cycles -> rsp_rdata 0xDEAD_BEEF, rsp_resp 00, arvalid high only until arready.
- Write to unmapped 0x10 with model giving BRESP 10 -> rsp_resp 10, err 1; next accepted command clears err.
- rsp_ready low for 5 cycles -> rsp_valid/rsp_* stable, cmd_ready 0, no new AXI activity; single transfer on release.
- aresetn asserted while awvalid high and awready low -> awvalid 0 immediately, busy 0; after release, a new read completes normally.
